score_recorder: RTL

- Downstream consumer of the game FSM score and the timer end-of-game flag.
- On each end of game: captures the final 8-bit score, updates a persistent best score, and converts both values to 3-digit BCD with a sequential shift-add converter.
- Presents one result record to the display/readout stage over a valid/ready handshake.
- Counts games played.

---
 rtl/score_pkg.sv | 26 ++
 rtl/score_recorder_bin2bcd_seq.sv | 62 ++++++
 rtl/score_recorder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the score recorder and its BCD converter.
package score_pkg;

    localparam int BCD_W       = 12;
    localparam int CONV_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CONV_LAST = 2'd1,
        CONV_BEST = 2'd2,
        PRESENT   = 2'd3
    } state_e;

    // One double-dabble iteration on {bcd[11:0], bin[7:0]}: add 3 to digits >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int d = 0; d < 3; d++) begin
            if (t[8 + 4*d +: 4] >= 4'd5) begin
                t[8 + 4*d +: 4] = t[8 + 4*d +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/score_recorder_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one double-dabble bit per cycle.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [19:0]      sr_q, sr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;

    // The first iteration is folded into the load so done lands exactly 8 cycles after start.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        bcd_d  = bcd_q;
        if (!busy_q) begin
            if (start) begin
                sr_d   = dd_step({12'd0, bin});
                cnt_d  = 3'd1;
                busy_d = 1'b1;
            end
        end else begin
            sr_d  = dd_step(sr_q);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(CONV_CYCLES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                bcd_d  = sr_d[19:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bcd_q  <= bcd_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_recorder.sv
// Captures the final score at each end of game, tracks the best score, converts both to BCD
// and presents them as one record over a valid/ready handshake.
module score_recorder
    import score_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               game_end,
    input  logic               clear_best,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [BCD_W-1:0]   last_bcd,
    output logic [BCD_W-1:0]   best_bcd,
    output logic               new_record,
    output logic [CNT_W-1:0]   games_played,
    output logic               busy
);

    state_e             state_q, state_d;
    logic               prev_end_q, prev_vld_q;
    logic [SCORE_W-1:0] cap_q, cap_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               pend_q, pend_d;
    logic [SCORE_W-1:0] pend_score_q, pend_score_d;
    logic               new_record_q, new_record_d;
    logic [BCD_W-1:0]   last_bcd_q, last_bcd_d;
    logic [BCD_W-1:0]   best_bcd_q, best_bcd_d;
    logic [CNT_W-1:0]   gp_q, gp_d;
    logic               start_q, start_d;

    logic               end_edge;
    logic               do_cap, use_clear;
    logic [SCORE_W-1:0] cap_val;
    logic [SCORE_W-1:0] conv_bin;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    // prev_vld_q masks the first cycle after reset so a level already high is not seen as an edge.
    assign end_edge = game_end & ~prev_end_q & prev_vld_q;
    assign conv_bin = (state_q == CONV_LAST) ? cap_q : best_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        best_d       = best_q;
        pend_d       = pend_q;
        pend_score_d = pend_score_q;
        new_record_d = new_record_q;
        last_bcd_d   = last_bcd_q;
        best_bcd_d   = best_bcd_q;
        gp_d         = gp_q;
        start_d      = 1'b0;
        do_cap       = 1'b0;
        use_clear    = 1'b0;
        cap_val      = score;

        case (state_q)
            IDLE: begin
                if (end_edge) begin
                    do_cap    = 1'b1;
                    use_clear = clear_best;
                end else if (clear_best) begin
                    best_d = '0;
                end
            end
            CONV_LAST: begin
                if (conv_done) begin
                    last_bcd_d = conv_bcd;
                    state_d    = CONV_BEST;
                    start_d    = 1'b1;
                end
            end
            CONV_BEST: begin
                if (conv_done) begin
                    best_bcd_d = conv_bcd;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (pend_q) begin
                        do_cap  = 1'b1;
                        cap_val = pend_score_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge outside IDLE wins over a pending score consumed in the same cycle.
        if (end_edge && (state_q != IDLE)) begin
            pend_d       = 1'b1;
            pend_score_d = score;
        end

        if (do_cap) begin
            cap_d   = cap_val;
            state_d = CONV_LAST;
            start_d = 1'b1;
            if (use_clear) begin
                best_d       = cap_val;
                new_record_d = (cap_val != '0);
            end else begin
                new_record_d = (cap_val > best_q);
                if (cap_val > best_q) begin
                    best_d = cap_val;
                end
            end
            if (gp_q != '1) begin
                gp_d = gp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_end_q   <= 1'b0;
            prev_vld_q   <= 1'b0;
            cap_q        <= '0;
            best_q       <= '0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            new_record_q <= 1'b0;
            last_bcd_q   <= '0;
            best_bcd_q   <= '0;
            gp_q         <= '0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_end_q   <= game_end;
            prev_vld_q   <= 1'b1;
            cap_q        <= cap_d;
            best_q       <= best_d;
            pend_q       <= pend_d;
            pend_score_q <= pend_score_d;
            new_record_q <= new_record_d;
            last_bcd_q   <= last_bcd_d;
            best_bcd_q   <= best_bcd_d;
            gp_q         <= gp_d;
            start_q      <= start_d;
        end
    end

    assign out_valid    = (state_q == PRESENT);
    assign busy         = (state_q != IDLE);
    assign last_bcd     = last_bcd_q;
    assign best_bcd     = best_bcd_q;
    assign new_record   = new_record_q;
    assign games_played = gp_q;

endmodule
